// File: rtl/bootram_loader_pkg.sv
// Shared definitions for the boot RAM byte-stream loader: FSM states,
// the sync marker and the byte offsets of the frame header fields.
package bootram_loader_pkg;

   typedef enum logic [2:0] {
      ST_SYNC,
      ST_ADDR_H,
      ST_ADDR_L,
      ST_LEN_H,
      ST_LEN_L,
      ST_DAT_L,
      ST_DAT_H,
      ST_CSUM
   } state_t;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   // Byte positions within a frame, counted from the sync byte.
   localparam int OFS_SYNC   = 0;
   localparam int OFS_ADDR_H = 1;
   localparam int OFS_ADDR_L = 2;
   localparam int OFS_LEN_H  = 3;
   localparam int OFS_LEN_L  = 4;
   localparam int OFS_DATA   = 5;

endpackage

// File: rtl/bootram_csum.sv
// 8-bit modulo-256 running sum with synchronous clear and add enable.
module bootram_csum (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       clear,
   input  logic       add,
   input  logic [7:0] din,
   output logic [7:0] sum
);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sum <= 8'h00;
      end else if (clear) begin
         sum <= 8'h00;
      end else if (add) begin
         sum <= sum + din;
      end
   end

endmodule

// File: rtl/bootram_loader.sv
// Byte-stream frame parser that writes 16-bit words into a boot RAM and
// reports frame completion with a checksum verdict.
module bootram_loader
   import bootram_loader_pkg::*;
#(
   parameter int ADDR = 13,
   parameter int DATA = 16
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [7:0]      in_data,
   input  logic            in_valid,
   output logic            in_ready,
   output logic            mem_we,
   output logic [ADDR-1:0] mem_addr,
   output logic [DATA-1:0] mem_write,
   output logic            busy,
   output logic            done,
   output logic            err,
   output logic [15:0]     word_cnt
);

   state_t          state_reg;
   logic [ADDR-9:0] addr_h_reg;
   logic [ADDR-1:0] addr_reg;
   logic [7:0]      len_h_reg;
   logic [15:0]     remaining_reg;
   logic [7:0]      dat_l_reg;
   logic [7:0]      csum_sum;
   logic [7:0]      csum_final;
   logic            accept;
   logic            sync_hit;

   // The only stall is the one cycle in which the frame verdict is shown.
   assign in_ready   = ~(done | err);
   assign busy       = (state_reg != ST_SYNC);
   assign accept     = in_valid & in_ready;
   assign sync_hit   = accept && (state_reg == ST_SYNC) && (in_data == SYNC_BYTE);
   assign csum_final = csum_sum + in_data;

   bootram_csum u_csum (
      .clk     (clk),
      .reset_n (reset_n),
      .clear   (sync_hit),
      .add     (accept && (state_reg != ST_SYNC)),
      .din     (in_data),
      .sum     (csum_sum)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg     <= ST_SYNC;
         addr_h_reg    <= '0;
         addr_reg      <= '0;
         len_h_reg     <= 8'h00;
         remaining_reg <= 16'h0000;
         dat_l_reg     <= 8'h00;
         mem_we        <= 1'b0;
         mem_addr      <= '0;
         mem_write     <= '0;
         done          <= 1'b0;
         err           <= 1'b0;
         word_cnt      <= 16'h0000;
      end else begin
         mem_we <= 1'b0;
         done   <= 1'b0;
         err    <= 1'b0;
         if (accept) begin
            case (state_reg)
               ST_SYNC: begin
                  if (in_data == SYNC_BYTE) begin
                     state_reg <= ST_ADDR_H;
                     word_cnt  <= 16'h0000;
                  end
               end
               ST_ADDR_H: begin
                  addr_h_reg <= in_data[ADDR-9:0];
                  state_reg  <= ST_ADDR_L;
               end
               ST_ADDR_L: begin
                  addr_reg  <= {addr_h_reg, in_data};
                  state_reg <= ST_LEN_H;
               end
               ST_LEN_H: begin
                  len_h_reg <= in_data;
                  state_reg <= ST_LEN_L;
               end
               ST_LEN_L: begin
                  remaining_reg <= {len_h_reg, in_data};
                  state_reg     <= ({len_h_reg, in_data} == 16'h0000) ? ST_CSUM : ST_DAT_L;
               end
               ST_DAT_L: begin
                  dat_l_reg <= in_data;
                  state_reg <= ST_DAT_H;
               end
               ST_DAT_H: begin
                  mem_we        <= 1'b1;
                  mem_addr      <= addr_reg;
                  mem_write     <= DATA'({in_data, dat_l_reg});
                  addr_reg      <= addr_reg + ADDR'(1);
                  word_cnt      <= word_cnt + 16'd1;
                  remaining_reg <= remaining_reg - 16'd1;
                  state_reg     <= (remaining_reg == 16'd1) ? ST_CSUM : ST_DAT_L;
               end
               ST_CSUM: begin
                  done      <= (csum_final == 8'h00);
                  err       <= (csum_final != 8'h00);
                  state_reg <= ST_SYNC;
               end
               default: state_reg <= ST_SYNC;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bootram_loader.sv
// Randomized scoreboard bench for bootram_loader: frames are built from a
// word list, expected writes and verdicts are queued, and a monitor checks them.
module tb_bootram_loader;
   import bootram_loader_pkg::*;

   localparam int ADDR = 13;
   localparam int DATA = 16;
   localparam int RAM_WORDS = 1 << ADDR;

   logic            clk = 1'b0;
   logic            reset_n;
   logic [7:0]      in_data;
   logic            in_valid;
   logic            in_ready;
   logic            mem_we;
   logic [ADDR-1:0] mem_addr;
   logic [DATA-1:0] mem_write;
   logic            busy;
   logic            done;
   logic            err;
   logic [15:0]     word_cnt;

   typedef struct { int addr; int data; } wr_t;
   typedef struct { bit ok; int cnt; } fr_t;

   wr_t wr_q[$];
   fr_t fr_q[$];
   int  words[$];
   int  model_ram[int];
   int  dut_ram[int];
   int  checks = 0;
   int  errors = 0;
   int  gap_max = 2;

   bootram_loader #(.ADDR(ADDR), .DATA(DATA)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_write (mem_write),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .word_cnt  (word_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Present one byte after a random idle gap and hold it until accepted.
   task automatic send_byte(input logic [7:0] b);
      int idle;
      int t;
      idle = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      repeat (idle) begin
         in_valid = 1'b0;
         in_data  = 8'($urandom);
         @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = b;
      t = 0;
      while (!in_ready && t < 20) begin
         @(posedge clk); #1;
         t++;
      end
      if (!in_ready) chk("ready_timeout", 0, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Build a frame from words[], queue the expected outcome, then send it.
   task automatic send_frame(input logic [15:0] start, input int len, input bit bad);
      logic [15:0] lenv;
      logic [7:0]  sum;
      logic [7:0]  cs;
      wr_t         w;
      fr_t         f;
      lenv = 16'(len);
      sum  = start[15:8] + start[7:0] + lenv[15:8] + lenv[7:0];
      for (int i = 0; i < len; i++) begin
         sum    = sum + 8'(words[i]) + 8'(words[i] >> 8);
         w.addr = (int'(start) + i) % RAM_WORDS;
         w.data = words[i];
         wr_q.push_back(w);
         model_ram[w.addr] = w.data;
      end
      cs = 8'h00 - sum;
      if (bad) cs = cs + 8'($urandom_range(1, 255));
      f.ok  = !bad;
      f.cnt = len;
      fr_q.push_back(f);
      send_byte(SYNC_BYTE);
      send_byte(start[15:8]);
      send_byte(start[7:0]);
      send_byte(lenv[15:8]);
      send_byte(lenv[7:0]);
      for (int i = 0; i < len; i++) begin
         send_byte(8'(words[i]));
         send_byte(8'(words[i] >> 8));
      end
      send_byte(cs);
   endtask

   task automatic fill_words(input int len);
      words.delete();
      for (int i = 0; i < len; i++) words.push_back(int'($urandom_range(0, 65535)));
   endtask

   // Monitor: every write and every verdict is matched against the queues.
   always begin
      wr_t e;
      fr_t f;
      @(posedge clk); #1;
      if (reset_n) begin
         if (mem_we) begin
            if (wr_q.size() == 0) begin
               chk("unexpected_write", 1, 0);
            end else begin
               e = wr_q.pop_front();
               chk("wr_addr", mem_addr, e.addr);
               chk("wr_data", mem_write, e.data);
               dut_ram[int'(mem_addr)] = int'(mem_write);
               $display("write addr=0x%04h data=0x%04h", mem_addr, mem_write);
            end
         end
         if (done || err) begin
            if (fr_q.size() == 0) begin
               chk("unexpected_verdict", 1, 0);
            end else begin
               f = fr_q.pop_front();
               chk("done", done, f.ok);
               chk("err", err, !f.ok);
               chk("word_cnt", word_cnt, f.cnt);
               chk("ready_low_on_verdict", in_ready, 0);
               $display("frame end done=%0b err=%0b word_cnt=%0d", done, err, word_cnt);
            end
         end
      end
   end

   initial begin
      reset_n  = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_write", mem_write, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_word_cnt", word_cnt, 0);
      chk("rst_in_ready", in_ready, 1);
      reset_n = 1'b1;
      @(posedge clk); #1;

      // Reference frame: two words at 0x010, good and then bad checksum.
      words = '{32'h1234, 32'h5678};
      send_frame(16'h0010, 2, 1'b0);
      send_frame(16'h0010, 2, 1'b1);

      // Junk before sync, then an empty frame.
      send_byte(8'h00);
      send_byte(8'hFF);
      send_byte(8'h5A);
      words.delete();
      send_frame(16'h0000, 0, 1'b0);

      // Address wrap and ignored upper start-address bits.
      fill_words(2);
      send_frame(16'h1FFF, 2, 1'b0);
      fill_words(3);
      send_frame(16'hFFFE, 3, 1'b0);

      // Frame abandoned by reset after the first low data byte.
      send_byte(SYNC_BYTE);
      send_byte(8'h00);
      send_byte(8'h20);
      send_byte(8'h00);
      send_byte(8'h03);
      send_byte(8'h77);
      reset_n = 1'b0;
      @(posedge clk); #1;
      chk("abort_mem_we", mem_we, 0);
      chk("abort_busy", busy, 0);
      chk("abort_in_ready", in_ready, 1);
      reset_n = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         chk("abort_idle_we", mem_we, 0);
      end
      fill_words(3);
      send_frame(16'h0020, 3, 1'b0);

      // Random frames, some with junk lead-in and some with bad checksums.
      for (int n = 0; n < 6; n++) begin
         if ($urandom_range(0, 1) == 1) send_byte(8'h3C);
         fill_words(int'($urandom_range(0, 6)));
         send_frame(16'($urandom_range(0, 65535)), words.size(), ($urandom_range(0, 3) == 0));
      end

      // Long frame with random valid gaps.
      gap_max = 3;
      fill_words(64);
      send_frame(16'($urandom_range(0, 65535)), 64, 1'b0);

      for (int t = 0; t < 200 && (wr_q.size() != 0 || fr_q.size() != 0); t++) begin
         @(posedge clk); #1;
      end
      chk("wr_q_drained", wr_q.size(), 0);
      chk("fr_q_drained", fr_q.size(), 0);
      foreach (model_ram[a]) begin
         chk("ram_contents", dut_ram.exists(a) ? dut_ram[a] : -1, model_ram[a]);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
